// File: rtl/bus_step_sequencer_pkg.sv
// rtl/bus_step_sequencer_pkg.sv - bus codes, state encodings, opcodes and op classes for the step sequencer.
// The T6 state exists only when HILO_WRITEBACK_EN is defined.
package bus_step_sequencer_pkg;

  localparam logic [4:0] SEL_ZHI = 5'd18;
  localparam logic [4:0] SEL_ZLO = 5'd19;
  localparam logic [4:0] SEL_PC  = 5'd20;
  localparam logic [4:0] SEL_MDR = 5'd21;

  localparam logic [4:0] OP_ALU_FIRST = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01010;
  localparam logic [4:0] OP_MUL       = 5'b01110;
  localparam logic [4:0] OP_DIV       = 5'b01111;
  localparam logic [4:0] OP_NOP       = 5'b11010;
  localparam logic [4:0] OP_HALT      = 5'b11011;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T1W  = 4'd3,
    ST_T2   = 4'd4,
    ST_T3   = 4'd5,
    ST_T4   = 4'd6,
    ST_T5   = 4'd7,
`ifdef HILO_WRITEBACK_EN
    ST_T6   = 4'd8,
`endif
    ST_HALT = 4'd9
  } seqState_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_NOP     = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } opClass_t;

endpackage

// File: rtl/ir_class_decode.sv
// rtl/ir_class_decode.sv - combinational opcode classifier; MUL/DIV are legal only with HILO_WRITEBACK_EN.
module ir_class_decode
  import bus_step_sequencer_pkg::*;
(
  input  logic [4:0] op,
  output opClass_t   opClass
);

  always_comb begin
    opClass = CLS_ILLEGAL;
    if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) begin
      opClass = CLS_ALU;
    end else if (op == OP_MUL || op == OP_DIV) begin
`ifdef HILO_WRITEBACK_EN
      opClass = CLS_MULDIV;
`else
      opClass = CLS_ILLEGAL;
`endif
    end else if (op == OP_NOP) begin
      opClass = CLS_NOP;
    end else if (op == OP_HALT) begin
      opClass = CLS_HALT;
    end
  end

endmodule

// File: rtl/bus_step_sequencer.sv
// rtl/bus_step_sequencer.sv - fetch/execute control-step sequencer driving the 32:1 bus mux select and load strobes.
// HILO_WRITEBACK_EN adds the T6 HI writeback step for MUL/DIV; otherwise those opcodes are illegal.
module bus_step_sequencer
  import bus_step_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic        stop,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [4:0]  bus_sel,
  output logic        mar_in,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        read,
  output logic        mdr_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        lo_in,
  output logic        hi_in,
  output logic [15:0] reg_in,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        mem_err
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  seqState_t  state;
  logic [7:0] waitCnt;
  opClass_t   opClass;
  logic       timeoutHit;
  logic [14:0] unusedIr;

  wire [4:0] op = ir[31:27];
  wire [3:0] ra = ir[26:23];
  wire [3:0] rb = ir[22:19];
  wire [3:0] rc = ir[18:15];

  assign unusedIr   = ir[14:0];
  assign timeoutHit = (waitCnt == WAIT_LAST);

  ir_class_decode uDecode (
    .op      (op),
    .opClass (opClass)
  );

  // The abort on timeout wins over a late mem_ready so mem_err always means an aborted fetch.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state   <= ST_IDLE;
      waitCnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start && !stop) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1: begin
          waitCnt <= '0;
          state   <= mem_ready ? ST_T2 : ST_T1W;
        end
        ST_T1W: begin
          if (timeoutHit) begin
            waitCnt <= '0;
            state   <= ST_IDLE;
          end else if (mem_ready) begin
            state <= ST_T2;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        ST_T2: state <= ST_T3;
        ST_T3: begin
          case (opClass)
            CLS_ALU, CLS_MULDIV: state <= ST_T4;
            CLS_HALT:            state <= ST_HALT;
            default:             state <= stop ? ST_IDLE : ST_T0;
          endcase
        end
        ST_T4: state <= ST_T5;
        ST_T5: begin
`ifdef HILO_WRITEBACK_EN
          if (opClass == CLS_MULDIV) state <= ST_T6;
          else                       state <= stop ? ST_IDLE : ST_T0;
`else
          state <= stop ? ST_IDLE : ST_T0;
`endif
        end
`ifdef HILO_WRITEBACK_EN
        ST_T6: state <= stop ? ST_IDLE : ST_T0;
`endif
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_sel = '0;
    mar_in  = 1'b0;
    pc_in   = 1'b0;
    inc_pc  = 1'b0;
    read    = 1'b0;
    mdr_in  = 1'b0;
    ir_in   = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    lo_in   = 1'b0;
    hi_in   = 1'b0;
    reg_in  = '0;
    alu_op  = '0;
    done    = 1'b0;
    illegal = 1'b0;
    mem_err = 1'b0;
    busy    = (state != ST_IDLE) && (state != ST_HALT);
    case (state)
      ST_T0: begin
        bus_sel = SEL_PC;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
      end
      ST_T1: begin
        bus_sel = SEL_ZLO;
        pc_in   = 1'b1;
        read    = 1'b1;
        mdr_in  = 1'b1;
      end
      ST_T1W: begin
        read    = 1'b1;
        mdr_in  = 1'b1;
        mem_err = timeoutHit;
      end
      ST_T2: begin
        bus_sel = SEL_MDR;
        ir_in   = 1'b1;
      end
      ST_T3: begin
        case (opClass)
          CLS_ALU, CLS_MULDIV: begin
            bus_sel = {1'b0, rb};
            y_in    = 1'b1;
          end
          CLS_NOP:     done = 1'b1;
          CLS_ILLEGAL: begin
            illegal = 1'b1;
            done    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        bus_sel = {1'b0, rc};
        alu_op  = op;
        z_in    = 1'b1;
      end
      ST_T5: begin
        bus_sel = SEL_ZLO;
`ifdef HILO_WRITEBACK_EN
        if (opClass == CLS_MULDIV) begin
          lo_in = 1'b1;
        end else begin
          reg_in = 16'h0001 << ra;
          done   = 1'b1;
        end
`else
        reg_in = 16'h0001 << ra;
        done   = 1'b1;
`endif
      end
`ifdef HILO_WRITEBACK_EN
      ST_T6: begin
        bus_sel = SEL_ZHI;
        hi_in   = 1'b1;
        done    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_step_sequencer.sv
// tb/tb_bus_step_sequencer.sv - self-checking bench for bus_step_sequencer; expectations follow HILO_WRITEBACK_EN.
module tb_bus_step_sequencer;

  localparam int TO = 15;

  typedef struct packed {
    logic [4:0]  busSel;
    logic        marIn, pcIn, incPc, rd, mdrIn, irIn, yIn, zIn, loIn, hiIn;
    logic [15:0] regIn;
    logic [4:0]  aluOp;
    logic        busy, done, illegal, memErr;
  } outV_t;

  typedef enum int {S_IDLE, S_T0, S_T1, S_T1W, S_T1WERR, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} step_e;

  localparam int C_ALU = 0, C_MULDIV = 1, C_NOP = 2, C_HALT = 3, C_ILL = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear_n, start, stop, mem_ready;
  logic [31:0] ir;
  logic [4:0]  bus_sel, alu_op;
  logic        mar_in, pc_in, inc_pc, read, mdr_in, ir_in, y_in, z_in, lo_in, hi_in;
  logic [15:0] reg_in;
  logic        busy, done, illegal, mem_err;

  bus_step_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .stop(stop), .mem_ready(mem_ready), .ir(ir),
    .bus_sel(bus_sel), .mar_in(mar_in), .pc_in(pc_in), .inc_pc(inc_pc), .read(read), .mdr_in(mdr_in),
    .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .lo_in(lo_in), .hi_in(hi_in), .reg_in(reg_in),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal), .mem_err(mem_err)
  );

  outV_t dutV;
  assign dutV = {bus_sel, mar_in, pc_in, inc_pc, read, mdr_in, ir_in, y_in, z_in, lo_in, hi_in,
                 reg_in, alu_op, busy, done, illegal, mem_err};

  int checks = 0;
  int errors = 0;
  outV_t expQ[$];
  outV_t cmpExp;
  logic [4:0]  busLog[$];
  logic [15:0] regLog[$];
  logic        loLog[$], hiLog[$], doneLog[$], illLog[$];
  int pcInCnt = 0, readCnt = 0, memErrCnt = 0, yInCnt = 0;

  function automatic int classOf(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd10) return C_ALU;
`ifdef HILO_WRITEBACK_EN
    if (op == 5'd14 || op == 5'd15) return C_MULDIV;
`endif
    if (op == 5'd26) return C_NOP;
    if (op == 5'd27) return C_HALT;
    return C_ILL;
  endfunction

  function automatic logic [31:0] mkIr(input int op, input int ra, input int rb, input int rc);
    return {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'h5a5a};
  endfunction

  // Expected outputs for one control step, derived from the step table and the instruction fields.
  function automatic outV_t expStep(input step_e s, input logic [31:0] irv);
    outV_t v;
    int cls;
    v = '0;
    cls = classOf(irv[31:27]);
    v.busy = !(s == S_IDLE || s == S_HALT);
    case (s)
      S_T0: begin v.busSel = 5'd20; v.marIn = 1; v.incPc = 1; v.zIn = 1; end
      S_T1: begin v.busSel = 5'd19; v.pcIn = 1; v.rd = 1; v.mdrIn = 1; end
      S_T1W: begin v.rd = 1; v.mdrIn = 1; end
      S_T1WERR: begin v.rd = 1; v.mdrIn = 1; v.memErr = 1; end
      S_T2: begin v.busSel = 5'd21; v.irIn = 1; end
      S_T3: begin
        if (cls == C_ALU || cls == C_MULDIV) begin v.busSel = {1'b0, irv[22:19]}; v.yIn = 1; end
        else if (cls == C_NOP) v.done = 1;
        else if (cls == C_ILL) begin v.illegal = 1; v.done = 1; end
      end
      S_T4: begin v.busSel = {1'b0, irv[18:15]}; v.aluOp = irv[31:27]; v.zIn = 1; end
      S_T5: begin
        v.busSel = 5'd19;
        if (cls == C_MULDIV) v.loIn = 1;
        else begin v.regIn = 16'h0001 << irv[26:23]; v.done = 1; end
      end
      S_T6: begin v.busSel = 5'd18; v.hiIn = 1; v.done = 1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  always @(negedge clock) begin
    busLog.push_back(bus_sel);
    regLog.push_back(reg_in);
    loLog.push_back(lo_in);
    hiLog.push_back(hi_in);
    doneLog.push_back(done);
    illLog.push_back(illegal);
    pcInCnt   += int'(pc_in);
    readCnt   += int'(read);
    memErrCnt += int'(mem_err);
    yInCnt    += int'(y_in);
    if (expQ.size() > 0) begin
      cmpExp = expQ.pop_front();
      checks++;
      if (dutV !== cmpExp) begin
        errors++;
        $display("FAIL cycle_compare t=%0t: got %h want %h", $time, dutV, cmpExp);
      end
    end
  end

  task automatic cyc(input step_e s);
    expQ.push_back(expStep(s, ir));
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction from T0; stop is raised at the first execute step when stopAtEnd is set.
  task automatic runInstr(input logic [31:0] irv, input int waits, input logic stopAtEnd);
    int cls;
    ir = irv;
    stop = 1'b0;
    cls = classOf(irv[31:27]);
    cyc(S_T0);
    mem_ready = (waits == 0);
    cyc(S_T1);
    mem_ready = 1'b0;
    for (int k = 1; k <= waits; k++) begin
      if (k == TO) begin
        cyc(S_T1WERR);
        return;
      end
      mem_ready = (k == waits);
      cyc(S_T1W);
      mem_ready = 1'b0;
    end
    cyc(S_T2);
    if (!(cls == C_ALU || cls == C_MULDIV)) stop = stopAtEnd;
    cyc(S_T3);
    if (cls == C_ALU || cls == C_MULDIV) begin
      stop = stopAtEnd;
      cyc(S_T4);
      cyc(S_T5);
      if (cls == C_MULDIV) cyc(S_T6);
    end
  endtask

  initial begin
    int base, pc0, rd0, me0, y0;
    logic [4:0] addSeq [6];
    logic [31:0] addIr, mulIr, haltIr;
    logic [31:0] table_ir [6];
    int table_w [6];
    addSeq = '{5'd20, 5'd19, 5'd21, 5'd3, 5'd4, 5'd19};
    addIr  = mkIr(3, 2, 3, 4);
    mulIr  = mkIr(14, 5, 6, 7);
    haltIr = mkIr(27, 0, 0, 0);
    table_ir = '{mkIr(26, 1, 1, 1), mkIr(2, 1, 2, 3), mkIr(11, 4, 5, 6),
                 mkIr(10, 15, 9, 8), mkIr(31, 0, 0, 0), mkIr(15, 3, 1, 2)};
    table_w  = '{0, 1, 2, 0, 1, 2};

    clear_n = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0; ir = '0;
    @(posedge clock); #1;
    chk("reset_outputs", 64'(dutV), 64'h0);
    cyc(S_IDLE);
    clear_n = 1'b1;
    cyc(S_IDLE);
    start = 1'b1; stop = 1'b1;
    cyc(S_IDLE);
    chk("stop_priority_idle_busy", 64'(busy), 64'h0);
    stop = 1'b0;
    cyc(S_IDLE);

    base = busLog.size();
    runInstr(addIr, 0, 1'b0);
    for (int i = 0; i < 6; i++) chk($sformatf("add_bus_sel_%0d", i), 64'(busLog[base + i]), 64'(addSeq[i]));
    chk("add_t5_reg_in", 64'(regLog[base + 5]), 64'h0004);
    chk("add_t5_done", 64'(doneLog[base + 5]), 64'h1);
    chk("add_no_gap_t0", 64'(bus_sel), 64'd20);

    pc0 = pcInCnt; rd0 = readCnt;
    runInstr(mkIr(7, 9, 10, 11), 3, 1'b0);
    chk("wait3_read_cycles", 64'(readCnt - rd0), 64'd4);
    chk("wait3_pc_in_once", 64'(pcInCnt - pc0), 64'd1);

    for (int i = 0; i < 6; i++) runInstr(table_ir[i], table_w[i], 1'b0);

    base = busLog.size(); y0 = yInCnt;
    runInstr(mulIr, 0, 1'b0);
`ifdef HILO_WRITEBACK_EN
    chk("mul_t5_bus_sel", 64'(busLog[base + 5]), 64'd19);
    chk("mul_t5_lo_in", 64'(loLog[base + 5]), 64'h1);
    chk("mul_t6_bus_sel", 64'(busLog[base + 6]), 64'd18);
    chk("mul_t6_hi_in", 64'(hiLog[base + 6]), 64'h1);
    chk("mul_t6_done", 64'(doneLog[base + 6]), 64'h1);
`else
    chk("mul_illegal_t3", 64'(illLog[base + 3]), 64'h1);
    chk("mul_no_y_in", 64'(yInCnt - y0), 64'd0);
`endif

    rd0 = readCnt; me0 = memErrCnt;
    runInstr(addIr, 1000, 1'b0);
    chk("timeout_mem_err_once", 64'(memErrCnt - me0), 64'd1);
    chk("timeout_read_cycles", 64'(readCnt - rd0), 64'(TO + 1));
    chk("timeout_idle_busy", 64'(busy), 64'h0);
    cyc(S_IDLE);

    runInstr(addIr, 0, 1'b1);
    chk("stop_idle_busy", 64'(busy), 64'h0);
    cyc(S_IDLE);
    stop = 1'b0;
    cyc(S_IDLE);

    ir = addIr;
    cyc(S_T0);
    mem_ready = 1'b1; cyc(S_T1); mem_ready = 1'b0;
    cyc(S_T2);
    cyc(S_T3);
    chk("pre_reset_t4_bus_sel", 64'(bus_sel), 64'd4);
    clear_n = 1'b0;
    #1;
    chk("reset_mid_t4_outputs", 64'(dutV), 64'h0);
    cyc(S_IDLE);
    clear_n = 1'b1;
    cyc(S_IDLE);
    chk("t0_after_reset_bus_sel", 64'(bus_sel), 64'd20);

    runInstr(haltIr, 0, 1'b0);
    repeat (4) cyc(S_HALT);
    chk("halt_held_busy", 64'(busy), 64'h0);
    clear_n = 1'b0;
    #1;
    chk("halt_reset_outputs", 64'(dutV), 64'h0);
    cyc(S_IDLE);
    clear_n = 1'b1; start = 1'b0;
    cyc(S_IDLE);
    chk("halt_exit_idle", 64'({busy, bus_sel}), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
